// File: rtl/pos_sweep_capture.sv
// ============================================================================
// Module   : pos_sweep_capture
// Summary  : Sweeps all 2^N input vectors through a combinational function,
//            captures its truth table, counts maxterms and checks it against
//            an expected mask.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module pos_sweep_capture #(
    parameter int N      = 4,
    parameter int SETTLE = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [(1<<N)-1:0]   expected,
    input  logic                dut_s,
    output logic [N-1:0]        vec,
    output logic                busy,
    output logic                done,
    output logic [(1<<N)-1:0]   mask,
    output logic [N:0]          zero_count,
    output logic                pass,
    output logic                mis_valid,
    output logic [N-1:0]        mis_index
);

    localparam logic [N-1:0] c_LAST   = {N{1'b1}};
    localparam logic [1:0]   c_SETTLE = 2'(SETTLE);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_APPLY = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 w_accept;
    logic                 w_sample;
    logic                 w_last;

    logic [N-1:0]         r_vec;
    logic [1:0]           r_wait;
    logic [(1<<N)-1:0]    r_exp;
    logic [(1<<N)-1:0]    r_mask;
    logic [N:0]           r_zero;
    logic                 r_pass;
    logic                 r_mis_valid;
    logic [N-1:0]         r_mis_index;
    logic                 r_busy;
    logic                 r_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_sample    = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_APPLY;
                end
            end
            S_APPLY: begin
                if (r_wait == c_SETTLE) begin
                    w_sample = 1'b1;
                    if (r_vec == c_LAST) begin
                        w_last      = 1'b1;
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // busy/done are registered from the state so they switch one edge after
    // the state does: busy rises the edge after start is taken, and busy
    // falls exactly as done rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vec       <= '0;
            r_wait      <= '0;
            r_exp       <= '0;
            r_mask      <= '0;
            r_zero      <= '0;
            r_pass      <= 1'b0;
            r_mis_valid <= 1'b0;
            r_mis_index <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_busy <= (r_state == S_APPLY);
            r_done <= (r_state == S_DONE);
            if (w_accept) begin
                r_exp       <= expected;
                r_mask      <= '0;
                r_zero      <= '0;
                r_pass      <= 1'b0;
                r_mis_valid <= 1'b0;
                r_mis_index <= '0;
                r_vec       <= '0;
                r_wait      <= '0;
            end else if (r_state == S_APPLY) begin
                if (w_sample) begin
                    r_mask[r_vec] <= dut_s;
                    if (!dut_s) begin
                        r_zero <= r_zero + 1'b1;
                    end
                    if ((dut_s != r_exp[r_vec]) && !r_mis_valid) begin
                        r_mis_valid <= 1'b1;
                        r_mis_index <= r_vec;
                    end
                    if (!w_last) begin
                        r_vec <= r_vec + 1'b1;
                    end
                    r_wait <= '0;
                end else begin
                    r_wait <= r_wait + 1'b1;
                end
            end else if (r_state == S_DONE) begin
                r_pass <= (r_mask == r_exp);
            end
        end
    end

    assign vec        = r_vec;
    assign busy       = r_busy;
    assign done       = r_done;
    assign mask       = r_mask;
    assign zero_count = r_zero;
    assign pass       = r_pass;
    assign mis_valid  = r_mis_valid;
    assign mis_index  = r_mis_index;

endmodule

`default_nettype wire

// File: tb/tb_pos_sweep_capture.sv
// ============================================================================
// Module   : tb_pos_sweep_capture
// Summary  : Directed bench for pos_sweep_capture with an N=3/SETTLE=1 and an
//            N=4/SETTLE=2 instance driving small reference functions.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_pos_sweep_capture;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start3, s3, busy3, done3, pass3, mv3;
    logic [7:0]  exp3, mask3;
    logic [2:0]  vec3, mi3;
    logic [3:0]  zc3;
    logic        start4, s4, busy4, done4, pass4, mv4, sel4;
    logic [15:0] exp4, mask4;
    logic [3:0]  vec4, mi4;
    logic [4:0]  zc4;

    int n_checks = 0;
    int n_fail   = 0;

    // (X|~Y|Z)&(X|~Y|~Z)&(~X|~Y|Z)&(~X|~Y|~Z) reduces to ~Y
    assign s3 = ~vec3[1];

    // PoS M(0,1,2,4,6,8,12,14), or constant 0 when sel4 is set
    always_comb begin
        s4 = 1'b1;
        case (vec4)
            4'd0, 4'd1, 4'd2, 4'd4, 4'd6, 4'd8, 4'd12, 4'd14: s4 = 1'b0;
            default: s4 = 1'b1;
        endcase
        if (sel4) s4 = 1'b0;
    end

    pos_sweep_capture #(.N(3), .SETTLE(1)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .expected(exp3), .dut_s(s3),
        .vec(vec3), .busy(busy3), .done(done3), .mask(mask3), .zero_count(zc3),
        .pass(pass3), .mis_valid(mv3), .mis_index(mi3)
    );

    pos_sweep_capture #(.N(4), .SETTLE(2)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .expected(exp4), .dut_s(s4),
        .vec(vec4), .busy(busy4), .done(done4), .mask(mask4), .zero_count(zc4),
        .pass(pass4), .mis_valid(mv4), .mis_index(mi4)
    );

    // Cycle counts are edges after the accepting edge; -1 means not seen.
    task automatic wait_done3(output int dcyc, output int bcyc);
        dcyc = -1; bcyc = -1;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk); #1;
            if (busy3 && bcyc < 0) bcyc = c;
            if (done3) begin dcyc = c; break; end
        end
    endtask

    task automatic wait_done4(output int dcyc, output int bcyc);
        dcyc = -1; bcyc = -1;
        for (int c = 1; c <= 300; c++) begin
            @(posedge clk); #1;
            if (busy4 && bcyc < 0) bcyc = c;
            if (done4) begin dcyc = c; break; end
        end
    endtask

    task automatic go3(input logic [7:0] e);
        @(negedge clk); exp3 = e; start3 = 1'b1;
        @(posedge clk); #1; start3 = 1'b0;
    endtask

    task automatic go4(input logic [15:0] e);
        @(negedge clk); exp4 = e; start4 = 1'b1;
        @(posedge clk); #1; start4 = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start3 = 1'b0; start4 = 1'b0; sel4 = 1'b0;
        exp3 = 8'h00; exp4 = 16'h0000;
        #3;
        n_checks++;
        if ({vec3, busy3, done3, mask3, zc3, pass3, mv3, mi3} !== 26'd0) begin
            n_fail++; $display("FAIL reset3: got %h want 0", {vec3, busy3, done3, mask3, zc3, pass3, mv3, mi3});
        end
        n_checks++;
        if ({vec4, busy4, done4, mask4, zc4, pass4, mv4, mi4} !== 33'd0) begin
            n_fail++; $display("FAIL reset4: got %h want 0", {vec4, busy4, done4, mask4, zc4, pass4, mv4, mi4});
        end
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_sweep3_pass();
        int d, b;
        go3(8'h33);
        n_checks++;
        if (busy3 !== 1'b0) begin n_fail++; $display("FAIL s3_busy_at_k: got %b want 0", busy3); end
        wait_done3(d, b);
        n_checks++;
        if (d != 17) begin n_fail++; $display("FAIL s3_done_cycle: got %0d want 17", d); end
        n_checks++;
        if (b != 1) begin n_fail++; $display("FAIL s3_busy_rise: got %0d want 1", b); end
        n_checks++;
        if (mask3 !== 8'h33) begin n_fail++; $display("FAIL s3_mask: got %h want 33", mask3); end
        n_checks++;
        if (zc3 !== 4'd4) begin n_fail++; $display("FAIL s3_zero_count: got %0d want 4", zc3); end
        n_checks++;
        if ({pass3, mv3, busy3} !== 3'b100) begin n_fail++; $display("FAIL s3_pass_mv_busy: got %b want 100", {pass3, mv3, busy3}); end
        n_checks++;
        if (vec3 !== 3'd7) begin n_fail++; $display("FAIL s3_vec_hold: got %0d want 7", vec3); end
        @(posedge clk); #1;
        n_checks++;
        if ({done3, pass3, vec3} !== 5'b01111) begin n_fail++; $display("FAIL s3_after_done: got %b want 01111", {done3, pass3, vec3}); end
    endtask

    task automatic test_sweep3_fail();
        int d, b;
        go3(8'h37);
        wait_done3(d, b);
        n_checks++;
        if (d != 17) begin n_fail++; $display("FAIL f3_done_cycle: got %0d want 17", d); end
        n_checks++;
        if ({pass3, mv3, mi3} !== 5'b01010) begin n_fail++; $display("FAIL f3_pass_mv_idx: got %b want 01010", {pass3, mv3, mi3}); end
        n_checks++;
        if (mask3 !== 8'h33) begin n_fail++; $display("FAIL f3_mask: got %h want 33", mask3); end
    endtask

    task automatic test_sweep4_pass();
        int d, b;
        go4(16'hAEA8);
        wait_done4(d, b);
        n_checks++;
        if (d != 49) begin n_fail++; $display("FAIL s4_done_cycle: got %0d want 49", d); end
        n_checks++;
        if (b != 1) begin n_fail++; $display("FAIL s4_busy_rise: got %0d want 1", b); end
        n_checks++;
        if (mask4 !== 16'hAEA8) begin n_fail++; $display("FAIL s4_mask: got %h want aea8", mask4); end
        n_checks++;
        if (zc4 !== 5'd8) begin n_fail++; $display("FAIL s4_zero_count: got %0d want 8", zc4); end
        n_checks++;
        if ({pass4, mv4} !== 2'b10) begin n_fail++; $display("FAIL s4_pass_mv: got %b want 10", {pass4, mv4}); end
    endtask

    task automatic test_const0();
        int d, b;
        sel4 = 1'b1;
        go4(16'h0000);
        wait_done4(d, b);
        sel4 = 1'b0;
        n_checks++;
        if (zc4 !== 5'd16) begin n_fail++; $display("FAIL c0_zero_count: got %0d want 16", zc4); end
        n_checks++;
        if ({pass4, mv4, mask4} !== {2'b10, 16'h0000}) begin n_fail++; $display("FAIL c0_pass_mask: got %b %h want 1 0 0000", pass4, mv4, mask4); end
    endtask

    task automatic test_start_ignored();
        int d;
        d = -1;
        go4(16'hAEA8);
        for (int c = 1; c <= 300; c++) begin
            @(posedge clk); #1;
            if (c == 9)  begin start4 = 1'b1; exp4 = 16'h0000; end
            if (c == 10) start4 = 1'b0;
            if (done4) begin d = c; break; end
        end
        n_checks++;
        if (d != 49) begin n_fail++; $display("FAIL ign_done_cycle: got %0d want 49", d); end
        n_checks++;
        if (pass4 !== 1'b1) begin n_fail++; $display("FAIL ign_pass: got %b want 1", pass4); end
    endtask

    task automatic test_reset_mid();
        int d, b;
        int seen;
        seen = 0;
        go3(8'h33);
        for (int c = 0; c < 100; c++) begin
            @(posedge clk); #1;
            if (vec3 == 3'd5) break;
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({vec3, busy3, done3, mask3, zc3, pass3, mv3, mi3} !== 26'd0) begin
            n_fail++; $display("FAIL mid_reset: got %h want 0", {vec3, busy3, done3, mask3, zc3, pass3, mv3, mi3});
        end
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (done3 || busy3) seen++;
        end
        n_checks++;
        if (seen != 0) begin n_fail++; $display("FAIL mid_no_done: got %0d active cycles want 0", seen); end
        go3(8'h33);
        wait_done3(d, b);
        n_checks++;
        if ({d[7:0], mask3, zc3, pass3} !== {8'd17, 8'h33, 4'd4, 1'b1}) begin
            n_fail++; $display("FAIL mid_clean_sweep: got %0d %h %0d %b want 17 33 4 1", d, mask3, zc3, pass3);
        end
    endtask

    task automatic test_back_to_back();
        int d, b;
        d = -1;
        @(negedge clk); exp3 = 8'h33; start3 = 1'b1;
        @(posedge clk); #1;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk); #1;
            if (c == 5) exp3 = 8'hFF;
            if (done3) begin d = c; break; end
        end
        n_checks++;
        if (d != 17) begin n_fail++; $display("FAIL b2b_done1: got %0d want 17", d); end
        n_checks++;
        if ({pass3, mv3} !== 2'b10) begin n_fail++; $display("FAIL b2b_latched: got %b want 10", {pass3, mv3}); end
        @(posedge clk); #1;
        start3 = 1'b0;
        n_checks++;
        if ({done3, busy3, pass3} !== 3'b000) begin n_fail++; $display("FAIL b2b_reaccept: got %b want 000", {done3, busy3, pass3}); end
        wait_done3(d, b);
        n_checks++;
        if (d != 17 || b != 1) begin n_fail++; $display("FAIL b2b_done2: got %0d/%0d want 17/1", d, b); end
        n_checks++;
        if ({pass3, mv3, mi3} !== 5'b01010) begin n_fail++; $display("FAIL b2b_second: got %b want 01010", {pass3, mv3, mi3}); end
    endtask

    initial begin
        test_reset();
        test_sweep3_pass();
        test_sweep3_fail();
        test_sweep4_pass();
        test_const0();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
